// File: rtl/reg_writeback_pkg.sv
// reg_writeback_pkg: source-select and FSM state constants shared by the writeback stage
package reg_writeback_pkg;
  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;
  localparam logic IDLE     = 1'b0;
  localparam logic WAIT_MEM = 1'b1;
endpackage

// File: rtl/reg_writeback_forward_cmp.sv
// wb_forward_cmp: matches the pending register-file write against fetch source indices
// Ports: wen/rd/data are the registered write port; rs1/rs2 are fetch indices;
// hit1/hit2 flag a match and fwd_data carries the pending write value.
module wb_forward_cmp #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int DBITS = 32
) (
  input  logic                           wen,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rd,
  input  logic [DBITS-1:0]               data,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rs2,
  output logic                           hit1,
  output logic                           hit2,
  output logic [DBITS-1:0]               fwd_data
);
  assign hit1 = wen && (rd == rs1);
  assign hit2 = wen && (rd == rs2);
  assign fwd_data = data;
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: writeback stage selecting ALU/load/PC+4 and driving the register-file write port
// Ports: in_* is the upstream result handshake; mem_rvalid/mem_rdata return load data;
// wrtEn/rd/wrtData drive the register file from flops; rs1/rs2 and fwd* form the
// optional forwarding path, enabled by defining WB_FORWARD_EN.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int DBITS = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_wrtEn,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] in_rd,
  input  logic [1:0]                     in_sel,
  input  logic [DBITS-1:0]               alu_result,
  input  logic [DBITS-1:0]               pc_plus4,
  input  logic                           mem_rvalid,
  input  logic [DBITS-1:0]               mem_rdata,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rs2,
  output logic                           wrtEn,
  output logic [REG_INDEX_BIT_WIDTH-1:0] rd,
  output logic [DBITS-1:0]               wrtData,
  output logic                           fwd1_hit,
  output logic                           fwd2_hit,
  output logic [DBITS-1:0]               fwd_data
);
  logic                           state_q, state_d;
  logic                           wen_q, wen_d;
  logic [REG_INDEX_BIT_WIDTH-1:0] rd_q, rd_d;
  logic [REG_INDEX_BIT_WIDTH-1:0] pend_rd_q, pend_rd_d;
  logic [DBITS-1:0]               data_q, data_d;
  logic                           xfer;
  assign in_ready = (state_q == IDLE);
  assign xfer = in_valid && in_ready;
  always_comb begin
    state_d = state_q;
    wen_d = 1'b0;
    rd_d = rd_q;
    data_d = data_q;
    pend_rd_d = pend_rd_q;
    if (state_q == IDLE) begin
      if (xfer && in_wrtEn && in_sel == SEL_MEM) begin
        state_d = WAIT_MEM;
        pend_rd_d = in_rd;
      end else if (xfer) begin
        wen_d = in_wrtEn;
        rd_d = in_rd;
        data_d = (in_sel == SEL_PC4) ? pc_plus4 : alu_result;
      end
    end else if (mem_rvalid) begin
      state_d = IDLE;
      wen_d = 1'b1;
      rd_d = pend_rd_q;
      data_d = mem_rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wen_q <= 1'b0;
      rd_q <= '0;
      data_q <= '0;
      pend_rd_q <= '0;
    end else begin
      state_q <= state_d;
      wen_q <= wen_d;
      rd_q <= rd_d;
      data_q <= data_d;
      pend_rd_q <= pend_rd_d;
    end
  end
  assign wrtEn = wen_q;
  assign rd = rd_q;
  assign wrtData = data_q;
`ifdef WB_FORWARD_EN
  wb_forward_cmp #(
    .REG_INDEX_BIT_WIDTH(REG_INDEX_BIT_WIDTH),
    .DBITS(DBITS)
  ) u_fwd (
    .wen(wen_q),
    .rd(rd_q),
    .data(data_q),
    .rs1(rs1),
    .rs2(rs2),
    .hit1(fwd1_hit),
    .hit2(fwd2_hit),
    .fwd_data(fwd_data)
  );
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign fwd1_hit = 1'b0;
  assign fwd2_hit = 1'b0;
  assign fwd_data = '0;
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: scoreboard bench for the writeback stage
module tb_reg_writeback;
  localparam logic [1:0] S_ALU = 2'b00;
  localparam logic [1:0] S_MEM = 2'b01;
  localparam logic [1:0] S_PC4 = 2'b10;
  typedef struct {
    int          cyc;
    logic [3:0]  rd;
    logic [31:0] data;
  } wr_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_wrtEn = 1'b0;
  logic [3:0]  in_rd = '0;
  logic [1:0]  in_sel = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] pc_plus4 = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  rs1 = '0;
  logic [3:0]  rs2 = '0;
  logic        wrtEn;
  logic [3:0]  rd;
  logic [31:0] wrtData;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd_data;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  wr_t sb[$];
  reg_writeback dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_wrtEn(in_wrtEn), .in_rd(in_rd), .in_sel(in_sel), .alu_result(alu_result),
    .pc_plus4(pc_plus4), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rs1(rs1), .rs2(rs2), .wrtEn(wrtEn), .rd(rd), .wrtData(wrtData),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic wen, input logic [3:0] r, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic exp_ready);
    wr_t e;
    in_valid = 1'b1;
    in_wrtEn = wen;
    in_rd = r;
    in_sel = sel;
    alu_result = alu;
    pc_plus4 = pc4;
    chk("in_ready", in_ready, exp_ready);
    if (exp_ready && wen && sel != S_MEM) begin
      e.cyc = cyc + 1;
      e.rd = r;
      e.data = (sel == S_PC4) ? pc4 : alu;
      sb.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (wrtEn === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_write", wrtEn, 1'b0);
      else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_rd", rd, e.rd);
        chk("wr_data", wrtData, e.data);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    wr_t e;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wrtEn", wrtEn, 0);
    chk("rst_rd", rd, 0);
    chk("rst_wrtData", wrtData, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fwd1", fwd1_hit, 0);
    chk("rst_fwd2", fwd2_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);
    tick();
    drive(1, 4'd1, S_ALU, 32'h11, 32'h0, 1);
    drive(1, 4'd2, S_ALU, 32'h22, 32'h0, 1);
    drive(1, 4'd3, 2'b11, 32'h33, 32'h0, 1);
    tick();
    drive(1, 4'd15, S_PC4, 32'hDEAD, 32'h104, 1);
    tick();
    drive(1, 4'd0, S_ALU, 32'hABC, 32'h0, 1);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    drive(1, 4'd5, S_MEM, 32'h77, 32'h0, 1);
    mem_rvalid = 1'b0;
    drive(1, 4'd9, S_ALU, 32'h99, 32'h0, 0);
    chk("wait_ready", in_ready, 0);
    tick();
    chk("wait_ready", in_ready, 0);
    mem_rvalid = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    e.cyc = cyc + 1;
    e.rd = 4'd5;
    e.data = 32'hCAFEF00D;
    sb.push_back(e);
    tick();
    mem_rvalid = 1'b0;
    chk("load_done_ready", in_ready, 1);
    tick();
    drive(0, 4'd3, S_MEM, 32'h0, 32'h0, 1);
    chk("nowrite_ready", in_ready, 1);
    tick();
    chk("nowrite_ready2", in_ready, 1);
    drive(1, 4'd7, S_ALU, 32'h55, 32'h0, 1);
    rs1 = 4'd7;
    rs2 = 4'd7;
    #1;
`ifdef WB_FORWARD_EN
    chk("fwd1_hit", fwd1_hit, 1);
    chk("fwd2_hit", fwd2_hit, 1);
    chk("fwd_data", fwd_data, 32'h55);
`else
    chk("fwd1_off", fwd1_hit, 0);
    chk("fwd2_off", fwd2_hit, 0);
    chk("fwd_data_off", fwd_data, 0);
`endif
    rs2 = 4'd6;
    #1;
    chk("fwd2_miss", fwd2_hit, 0);
`ifdef WB_FORWARD_EN
    chk("fwd1_still", fwd1_hit, 1);
`else
    chk("fwd1_off2", fwd1_hit, 0);
`endif
    tick();
    #1;
    chk("fwd1_nowrite", fwd1_hit, 0);
    drive(1, 4'd4, S_MEM, 32'h0, 32'h0, 1);
    chk("rstload_wait", in_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstload_ready", in_ready, 1);
    chk("rstload_wrtEn", wrtEn, 0);
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1234;
    tick();
    mem_rvalid = 1'b0;
    tick();
    tick();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
